// File: rtl/alu_seq_param_if.sv
// Operand/result bus for alu_seq_param: input handshake, output handshake and status.
interface alu_seq_param_if #(
  parameter int WIDTH = 4
);
  logic [2:0]       Select;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] RegOut;
  logic             Carryout;
  logic             Zero;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  // Source/consumer side: drives operands and takes results.
  modport master (
    output Select, A, B, C, in_valid, out_ready,
    input  in_ready, RegOut, Carryout, Zero, out_valid, busy
  );

  // ALU side.
  modport slave (
    input  Select, A, B, C, in_valid, out_ready,
    output in_ready, RegOut, Carryout, Zero, out_valid, busy
  );
endinterface

// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit 8-mode ALU with valid/ready handshakes on both sides and
// a multi-cycle rotate-through-carry (opcode 101) by a count taken from B.
module alu_seq_param #(
  parameter int WIDTH = 4
) (
  input logic           clock,
  input logic           reset,
  alu_seq_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rot_q, rot_d;
  logic             rcarry_q, rcarry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] reg_out_q, reg_out_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic [CW-1:0]    k_raw;
  logic [CW-1:0]    k_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_rot;
  logic             step_c;
  logic [WIDTH-1:0] res_val;
  logic             res_c;
  logic             res_we;

  assign bus.in_ready  = in_ready;
  assign bus.RegOut    = reg_out_q;
  assign bus.Carryout  = carry_out_q;
  assign bus.Zero      = zero_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == SHIFT);

  // Input handshake, clamped rotate count, adder and the single rotate step.
  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    k_raw    = bus.B[CW-1:0];
    k_eff    = (k_raw > CW'(WIDTH)) ? CW'(WIDTH) : k_raw;
    sum      = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.C};
    step_rot = {rot_q[WIDTH-2:0], rcarry_q};
    step_c   = rot_q[WIDTH-1];
  end

  // Next-state, working registers and result register update.
  always_comb begin
    state_d     = state_q;
    rot_d       = rot_q;
    rcarry_d    = rcarry_q;
    cnt_d       = cnt_q;
    reg_out_d   = reg_out_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    res_val     = '0;
    res_c       = 1'b0;
    res_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          res_we = 1'b1;
          case (bus.Select)
            3'b000: res_val = ~bus.A;
            3'b001: {res_c, res_val} = sum;
            3'b010: res_val = bus.A & bus.B;
            3'b011: res_val = bus.A | bus.B;
            3'b100: res_val = bus.A ^ bus.B;
            3'b101: begin
              if (k_eff == '0) begin
                res_val = bus.A;
                res_c   = bus.C;
              end else begin
                res_we   = 1'b0;
                state_d  = SHIFT;
                rot_d    = bus.A;
                rcarry_d = bus.C;
                cnt_d    = k_eff;
              end
            end
            3'b110: res_val = '0;
            default: res_val = '1;
          endcase
        end
      end
      SHIFT: begin
        rot_d    = step_rot;
        rcarry_d = step_c;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          res_we  = 1'b1;
          res_val = step_rot;
          res_c   = step_c;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (res_we) begin
      reg_out_d   = res_val;
      carry_out_d = res_c;
      zero_d      = (res_val == '0);
      out_valid_d = 1'b1;
    end
  end

  // State and data registers; reset discards any in-flight rotate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rot_q       <= '0;
      rcarry_q    <= 1'b0;
      cnt_q       <= '0;
      reg_out_q   <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rot_q       <= rot_d;
      rcarry_q    <= rcarry_d;
      cnt_q       <= cnt_d;
      reg_out_q   <= reg_out_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_alu_seq_param;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic clock;
  logic reset;

  alu_seq_param_if #(.WIDTH(W)) bus ();

  alu_seq_param #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    longint res;
    int     due;
  } exp_t;

  exp_t q[$];
  int   cycle;
  int   checkCount;
  int   errorCount;

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Reference result as {carry, value}; latency = effective rotate count (0 for single-cycle).
  function automatic longint modelCalc(input logic [2:0] sel, input longint a, input longint b,
                                       input logic c, output int lat);
    longint mask;
    longint full;
    longint v;
    int     k;
    mask = (longint'(1) << W) - 1;
    full = (longint'(1) << (W + 1)) - 1;
    lat  = 0;
    case (sel)
      3'd0: modelCalc = (~a) & mask;
      3'd1: modelCalc = a + b + longint'(c);
      3'd2: modelCalc = a & b;
      3'd3: modelCalc = a | b;
      3'd4: modelCalc = a ^ b;
      3'd5: begin
        k = int'(b & ((longint'(1) << CW) - 1));
        if (k > W) k = W;
        lat = k;
        v   = (longint'(c) << W) | a;
        if (k == 0) modelCalc = v;
        else        modelCalc = ((v << k) | (v >> (W + 1 - k))) & full;
      end
      3'd6: modelCalc = 0;
      default: modelCalc = mask;
    endcase
  endfunction

  // One clock cycle: check outputs, drive inputs, update the model at the edge.
  task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic c, input logic ordy);
    logic   expValid;
    logic   expBusy;
    logic   expInReady;
    logic   accept;
    logic   handshake;
    longint res;
    int     lat;
    expValid = (q.size() > 0) && (q[0].due <= cycle);
    expBusy  = (q.size() > 0) && (q[0].due > cycle);
    checkOutput("out_valid", longint'(bus.out_valid), longint'(expValid));
    checkOutput("busy", longint'(bus.busy), longint'(expBusy));
    if (expValid) begin
      checkOutput("RegOut", longint'(bus.RegOut), q[0].res & ((longint'(1) << W) - 1));
      checkOutput("Carryout", longint'(bus.Carryout), (q[0].res >> W) & 1);
      checkOutput("Zero", longint'(bus.Zero), longint'((q[0].res & ((longint'(1) << W) - 1)) == 0));
    end
    bus.in_valid  = v;
    bus.Select    = sel;
    bus.A         = a;
    bus.B         = b;
    bus.C         = c;
    bus.out_ready = ordy;
    #1;
    expInReady = !expBusy && (!expValid || ordy);
    checkOutput("in_ready", longint'(bus.in_ready), longint'(expInReady));
    accept    = v && expInReady;
    handshake = expValid && ordy;
    res       = modelCalc(sel, longint'(a), longint'(b), c, lat);
    @(posedge clock);
    cycle++;
    if (handshake) void'(q.pop_front());
    if (accept) q.push_back('{res: res, due: cycle + lat});
    @(negedge clock);
  endtask

  // Asynchronous reset pulse in the middle of a cycle, checked before the next edge.
  task automatic pulseReset();
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_out_valid", longint'(bus.out_valid), 0);
    checkOutput("rst_busy", longint'(bus.busy), 0);
    checkOutput("rst_RegOut", longint'(bus.RegOut), 0);
    checkOutput("rst_Carryout", longint'(bus.Carryout), 0);
    checkOutput("rst_Zero", longint'(bus.Zero), 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    cycle         = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.Select    = 3'b000;
    bus.A         = '0;
    bus.B         = '0;
    bus.C         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    checkOutput("init_RegOut", longint'(bus.RegOut), 0);
    checkOutput("init_Carryout", longint'(bus.Carryout), 0);
    checkOutput("init_Zero", longint'(bus.Zero), 0);
    checkOutput("init_out_valid", longint'(bus.out_valid), 0);
    checkOutput("init_busy", longint'(bus.busy), 0);
    checkOutput("init_in_ready", longint'(bus.in_ready), 1);
    reset = 1'b0;

    $display("[TB] directed scenarios");
    applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b001, 4'b1011, 4'b0110, 1'b1, 1'b1);
    applyStimulus(1'b1, 3'b101, 4'b1001, 4'b0010, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b111, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b101, 4'b1001, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b110, 4'b0101, 4'b0011, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b010, 4'b1100, 4'b1010, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b011, 4'b1100, 4'b1010, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b100, 4'b1100, 4'b1010, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b111, 4'b1100, 4'b1010, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b101, 4'b0110, 4'b0111, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);

    $display("[TB] reset during rotate");
    applyStimulus(1'b1, 3'b101, 4'b1011, 4'b0011, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    pulseReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      logic [2:0] sel;
      sel = ($urandom_range(0, 3) == 0) ? 3'b101 : 3'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), sel, W'($urandom), W'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < W + 2; i++) applyStimulus(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
